control_32: RTL and testbench
=============================

# control_32

Main control decoder for the 32-bit MIPS datapath. It decodes the 6-bit instruction opcode into the datapath control strobes and a 2-bit ALU-op class, and flags unsupported opcodes. It sits between instruction fetch/decode and the register file, ALU-control, data-memory and PC-select logic. All outputs are registered.

## Interface
Parameters: none.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction bits [31:26]
- alu_op  output  2  ALU class: 00 add (address/immediate), 01 subtract (branch compare), 10 use funct field
- mem_toreg  output  1  register write-back data from memory (1) or ALU (0)
- mem_write  output  1  data-memory write enable
- mem_read  output  1  data-memory read enable
- branch  output  1  conditional branch (beq)
- alu_src  output  1  ALU operand B is sign-extended immediate (1) or rt (0)
- reg_dst  output  1  destination register is rd (1) or rt (0)
- reg_write  output  1  register-file write enable
- jump  output  1  unconditional jump
- err_illegal_opcode  output  1  opcode not in the supported set

## Operation
- Combinational decode of `opcode`, then one output register stage.
- Control word below is listed as reg_write, reg_dst, alu_src, branch, mem_write, mem_read, mem_toreg, jump; alu_op; err.
- 000000 R-type: 1,1,0,0,0,0,0,0; 10; 0
- 100011 lw: 1,0,1,0,0,1,1,0; 00; 0
- 101011 sw: 0,0,1,0,1,0,0,0; 00; 0
- 000100 beq: 0,0,0,1,0,0,0,0; 01; 0
- 001000 addi: 1,0,1,0,0,0,0,0; 00; 0
- 000010 j: 0,0,0,0,0,0,0,1; 00; 0
- Any other opcode: all eight strobes 0, alu_op 00, err_illegal_opcode 1.
- Fields that are don't-care for an instruction are driven to 0. An illegal opcode never asserts a write enable.
- err_illegal_opcode is not sticky. It tracks the current registered opcode only.

## Timing
- Latency is 1 cycle. The outputs after rising edge N reflect the opcode sampled at edge N.
- rst_n low clears all outputs to 0 immediately, without waiting for clk, and holds them at 0. This includes alu_op = 00 and err_illegal_opcode = 0.
- After rst_n deasserts, the first rising edge loads the decode of the opcode present at that edge.
- Reset asserted mid-stream overrides any decode in the same cycle.
- Opcode changes between edges have no effect on the outputs until the next edge. No glitches appear on the outputs.
- Back-to-back opcodes are accepted every cycle. There is no handshake.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALU-op constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10
  - a packed control-word struct in the order listed above
- One natural sub-module: `control_decode`, a purely combinational opcode-to-control-word decoder. control_32 wraps it with the reset register stage.

## Test plan
- Reset: hold rst_n = 0 with opcode = 100011 → all outputs 0 asynchronously. Release rst_n → outputs unchanged until the next rising edge.
- Legal sweep, one opcode per cycle, with the control word listed as reg_write..jump; alu_op; err:
  - 000000 → 11000000; 10; 0
  - 100011 → 10100110; 00; 0
  - 101011 → 00101000; 00; 0
  - 000100 → 00010000; 01; 0
  - 001000 → 10100000; 00; 0
  - 000010 → 00000001; 00; 0
- Illegal sweep: 001110, 111111, 111011, 011110, 111010, 100111 → word 00000000, alu_op 00, err 1 each cycle.
- Latency: change opcode from 000000 to 100011 mid-cycle → outputs switch only at the next rising edge.
- Recovery: apply illegal 111111 then 000100 → err 1 for one cycle, then 0 with branch = 1.
- Reset mid-stream: pulse rst_n low between edges while lw is decoded → outputs go to 0 immediately, then resume decoding on the first edge after release.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcodes, ALU-op classes and control-word type for the
//               32-bit MIPS main control path.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       mem_toreg;
    logic       jump;
    logic [1:0] alu_op;
    logic       err;
  } ctrl_word_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module      : control_decode
// Description : Purely combinational opcode to control-word decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.mem_toreg = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch    = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        ctrl.jump      = 1'b1;
      end
      // Unsupported opcodes keep every strobe low so no write can leak out.
      default: begin
        ctrl.err       = 1'b1;
      end
    endcase
  end

endmodule : control_decode
`default_nettype wire

// File: rtl/control_32.sv
`default_nettype none
// ============================================================================
// Module      : control_32
// Description : Main control unit for the 32-bit MIPS datapath; decoded
//               control strobes are registered once with async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module control_32
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic [1:0] alu_op,
  output logic       mem_toreg,
  output logic       mem_write,
  output logic       mem_read,
  output logic       branch,
  output logic       alu_src,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       jump,
  output logic       err_illegal_opcode
);

  ctrl_word_t w_ctrl;
  ctrl_word_t r_ctrl;

  control_decode u_control_decode (
    .opcode (opcode),
    .ctrl   (w_ctrl)
  );

  // Registering the whole word keeps the outputs glitch-free between edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else begin
      r_ctrl <= w_ctrl;
    end
  end

  assign reg_write          = r_ctrl.reg_write;
  assign reg_dst            = r_ctrl.reg_dst;
  assign alu_src            = r_ctrl.alu_src;
  assign branch             = r_ctrl.branch;
  assign mem_write          = r_ctrl.mem_write;
  assign mem_read           = r_ctrl.mem_read;
  assign mem_toreg          = r_ctrl.mem_toreg;
  assign jump               = r_ctrl.jump;
  assign alu_op             = r_ctrl.alu_op;
  assign err_illegal_opcode = r_ctrl.err;

endmodule : control_32
`default_nettype wire

// File: tb/tb_control_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_32
// Description : Directed self-checking bench for control_32.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_control_32;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [1:0] alu_op;
  logic       mem_toreg, mem_write, mem_read, branch;
  logic       alu_src, reg_dst, reg_write, jump, err_illegal_opcode;

  int checks = 0;
  int errors = 0;

  // Observed word: reg_write..jump (8), alu_op (2), err (1)
  logic [10:0] obs;
  assign obs = {reg_write, reg_dst, alu_src, branch, mem_write, mem_read,
                mem_toreg, jump, alu_op, err_illegal_opcode};

  localparam logic [10:0] c_zero  = 11'b00000000_00_0;
  localparam logic [10:0] c_rtype = 11'b11000000_10_0;
  localparam logic [10:0] c_lw    = 11'b10100110_00_0;
  localparam logic [10:0] c_sw    = 11'b00101000_00_0;
  localparam logic [10:0] c_beq   = 11'b00010000_01_0;
  localparam logic [10:0] c_addi  = 11'b10100000_00_0;
  localparam logic [10:0] c_j     = 11'b00000001_00_0;
  localparam logic [10:0] c_ill   = 11'b00000000_00_1;

  control_32 dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .opcode             (opcode),
    .alu_op             (alu_op),
    .mem_toreg          (mem_toreg),
    .mem_write          (mem_write),
    .mem_read           (mem_read),
    .branch             (branch),
    .alu_src            (alu_src),
    .reg_dst            (reg_dst),
    .reg_write          (reg_write),
    .jump               (jump),
    .err_illegal_opcode (err_illegal_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n  = 1'b0;
    opcode = 6'b100011;
    #3;
    checks++;
    if (obs !== c_zero) begin
      errors++;
      $display("FAIL reset_async obs=%b exp=%b", obs, c_zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== c_zero) begin
      errors++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, c_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== c_zero) begin
      errors++;
      $display("FAIL reset_release_no_edge obs=%b exp=%b", obs, c_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_lw) begin
      errors++;
      $display("FAIL reset_first_edge obs=%b exp=%b", obs, c_lw);
    end
  endtask

  task automatic test_legal_sweep;
    logic [5:0]  ops [0:5];
    logic [10:0] exp [0:5];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    exp = '{c_rtype, c_lw, c_sw, c_beq, c_addi, c_j};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      opcode = ops[i];
      @(posedge clk);
      #1;
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL legal_%b obs=%b exp=%b", ops[i], obs, exp[i]);
      end
    end
  endtask

  task automatic test_illegal_sweep;
    logic [5:0] ops [0:5];
    ops = '{6'b001110, 6'b111111, 6'b111011, 6'b011110, 6'b111010, 6'b100111};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      opcode = ops[i];
      @(posedge clk);
      #1;
      checks++;
      if (obs !== c_ill) begin
        errors++;
        $display("FAIL illegal_%b obs=%b exp=%b", ops[i], obs, c_ill);
      end
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    opcode = 6'b000000;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_rtype) begin
      errors++;
      $display("FAIL latency_rtype obs=%b exp=%b", obs, c_rtype);
    end
    opcode = 6'b100011;
    #3;
    checks++;
    if (obs !== c_rtype) begin
      errors++;
      $display("FAIL latency_hold obs=%b exp=%b", obs, c_rtype);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_lw) begin
      errors++;
      $display("FAIL latency_switch obs=%b exp=%b", obs, c_lw);
    end
  endtask

  task automatic test_recovery;
    @(negedge clk);
    opcode = 6'b111111;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_ill) begin
      errors++;
      $display("FAIL recovery_err obs=%b exp=%b", obs, c_ill);
    end
    @(negedge clk);
    opcode = 6'b000100;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_beq) begin
      errors++;
      $display("FAIL recovery_beq obs=%b exp=%b", obs, c_beq);
    end
  endtask

  task automatic test_reset_midstream;
    @(negedge clk);
    opcode = 6'b100011;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_lw) begin
      errors++;
      $display("FAIL midreset_pre obs=%b exp=%b", obs, c_lw);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== c_zero) begin
      errors++;
      $display("FAIL midreset_async obs=%b exp=%b", obs, c_zero);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== c_zero) begin
      errors++;
      $display("FAIL midreset_release obs=%b exp=%b", obs, c_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== c_lw) begin
      errors++;
      $display("FAIL midreset_resume obs=%b exp=%b", obs, c_lw);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    test_reset();
    test_legal_sweep();
    test_illegal_sweep();
    test_latency();
    test_recovery();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_control_32
`default_nettype wire
